// File: rtl/bsg_unconcentrate_sched_pkg.sv
// Shared types and helpers for the runtime-mask unconcentrate scheduler.
package bsg_unconcentrate_sched_pkg;

  typedef enum logic [0:0] {
    eIdle  = 1'b0,
    eDrain = 1'b1
  } bsg_unconc_sched_state_e;

  // Lane-index width, never less than one bit so single-lane builds stay legal.
  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefaultEls      = 4;
  localparam int unsigned DefaultLaneIdxW = lane_idx_w(DefaultEls);

endpackage

// File: rtl/bsg_unconcentrate_dynamic.sv
// Combinational runtime-mask unconcentrate: packed element k lands on the k-th set
// bit of mask_i; lanes with a clear mask bit carry unconnected_val_p.
module bsg_unconcentrate_dynamic
  import bsg_unconcentrate_sched_pkg::*;
#(
  parameter int unsigned els_p             = 4,
  parameter int unsigned width_p           = 8,
  parameter logic        unconnected_val_p = 1'b0
) (
  input  logic [els_p-1:0]         mask_i,
  input  logic [els_p*width_p-1:0] data_i,
  output logic [els_p*width_p-1:0] data_o
);

  localparam int unsigned IdxW = lane_idx_w(els_p);

  logic [IdxW-1:0] k;

  // k is the prefix popcount of mask_i below lane j.
  always_comb begin
    data_o = {(els_p*width_p){unconnected_val_p}};
    k      = '0;
    for (int unsigned j = 0; j < els_p; j++) begin
      if (mask_i[j]) begin
        data_o[j*width_p +: width_p] = data_i[k*width_p +: width_p];
        k = k + IdxW'(1);
      end
    end
  end

endmodule

// File: rtl/bsg_unconcentrate_sched.sv
// Handshaked runtime-mask unconcentrate scheduler. Optional macro
// BSG_UNCONCENTRATE_SCHED_BYPASS_EN lets a new transaction enter as the last lanes drain.
module bsg_unconcentrate_sched
  import bsg_unconcentrate_sched_pkg::*;
#(
  parameter int unsigned els_p             = 4,
  parameter int unsigned width_p           = 8,
  parameter logic        unconnected_val_p = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [els_p-1:0]         mask_i,
  input  logic [els_p*width_p-1:0] data_i,
  output logic                     ready_o,
  output logic [els_p-1:0]         v_o,
  output logic [els_p*width_p-1:0] data_o,
  input  logic [els_p-1:0]         ready_i,
  output logic                     busy_o
);

  bsg_unconc_sched_state_e  state_q;
  logic [els_p-1:0]         pending_q;
  logic [els_p*width_p-1:0] data_q;
  logic [els_p*width_p-1:0] spread;
  logic [els_p-1:0]         hs;
  logic                     done;
  logic                     load;

  bsg_unconcentrate_dynamic #(
    .els_p            (els_p),
    .width_p          (width_p),
    .unconnected_val_p(unconnected_val_p)
  ) u_spread (
    .mask_i(mask_i),
    .data_i(data_i),
    .data_o(spread)
  );

  assign hs   = pending_q & ready_i;
  assign done = ((pending_q & ~hs) == '0);

`ifdef BSG_UNCONCENTRATE_SCHED_BYPASS_EN
  assign ready_o = (state_q == eIdle) | done;
`else
  assign ready_o = (state_q == eIdle);
`endif

  // Zero-mask transactions are consumed without loading anything.
  assign load   = v_i & ready_o & (|mask_i);
  assign v_o    = pending_q;
  assign data_o = data_q;
  assign busy_o = (state_q == eDrain);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= eIdle;
      pending_q <= '0;
      data_q    <= {(els_p*width_p){unconnected_val_p}};
    end else begin
      unique case (state_q)
        eIdle: begin
          if (load) begin
            pending_q <= mask_i;
            data_q    <= spread;
            state_q   <= eDrain;
          end
        end
        eDrain: begin
          pending_q <= pending_q & ~hs;
          if (done) begin
            if (load) begin
              pending_q <= mask_i;
              data_q    <= spread;
            end else begin
              state_q <= eIdle;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_unconcentrate_sched.sv
// Self-checking bench for bsg_unconcentrate_sched: directed table, corner sequences and
// random traffic against a per-lane queue scoreboard.
module tb_bsg_unconcentrate_sched;

  localparam int unsigned Els = 4;
  localparam int unsigned W   = 8;
`ifdef BSG_UNCONCENTRATE_SCHED_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             v_i = 1'b0;
  logic [Els-1:0]   mask_i = '0;
  logic [Els*W-1:0] data_i = '0;
  logic             ready_o;
  logic [Els-1:0]   v_o;
  logic [Els*W-1:0] data_o;
  logic [Els-1:0]   ready_i = '0;
  logic             busy_o;

  bsg_unconcentrate_sched #(
    .els_p            (Els),
    .width_p          (W),
    .unconnected_val_p(1'b0)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .v_i      (v_i),
    .mask_i   (mask_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .ready_i  (ready_i),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard: elements still owed to each lane, plus what each idle lane shows.
  logic [W-1:0] q [Els][$];
  logic [W-1:0] last_d [Els];
  logic [W-1:0] lane0_log [$];
  bit           last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [Els-1:0] owed();
    logic [Els-1:0] m = '0;
    for (int j = 0; j < Els; j++) m[j] = (q[j].size() != 0);
    return m;
  endfunction

  function automatic logic [Els*W-1:0] exp_data();
    logic [Els*W-1:0] d;
    for (int j = 0; j < Els; j++) d[j*W +: W] = (q[j].size() != 0) ? q[j][0] : last_d[j];
    return d;
  endfunction

  function automatic bit exp_ready();
    logic [Els-1:0] m = owed();
    return (m == '0) || (Byp && ((m & ~ready_i) == '0));
  endfunction

  task automatic model_reset();
    for (int j = 0; j < Els; j++) begin
      q[j].delete();
      last_d[j] = '0;
    end
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic tick();
    logic [Els-1:0]   hs;
    logic [Els-1:0]   m;
    logic [Els*W-1:0] din;
    bit               acc;
    int               k;
    #1;
    m = owed();
    chk("v_o", 64'(v_o), 64'(m));
    chk("data_o", 64'(data_o), 64'(exp_data()));
    chk("busy_o", 64'(busy_o), 64'(m != '0));
    chk("ready_o", 64'(ready_o), 64'(exp_ready()));
    hs  = m & ready_i;
    acc = v_i && exp_ready();
    din = data_i;
    @(posedge clk);
    for (int j = 0; j < Els; j++) begin
      if (hs[j]) begin
        last_d[j] = q[j].pop_front();
        if (j == 0) lane0_log.push_back(last_d[j]);
      end
    end
    if (acc && mask_i != '0) begin
      k = 0;
      for (int j = 0; j < Els; j++) begin
        if (mask_i[j]) begin
          q[j].push_back(din[k*W +: W]);
          k++;
        end else begin
          last_d[j] = '0;
        end
      end
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  typedef struct {
    logic [Els-1:0]   mask;
    logic [Els*W-1:0] data;
    logic [Els*W-1:0] exp_d;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int edges;
    int sent;
    vecs[0] = '{4'b1010, 32'h0000_BBAA, 32'hBB00_AA00};
    vecs[1] = '{4'b1111, 32'h4433_2211, 32'h4433_2211};
    vecs[2] = '{4'b0001, 32'hFFFF_FF5A, 32'h0000_005A};
    vecs[3] = '{4'b1000, 32'h1234_5677, 32'h7700_0000};
    vecs[4] = '{4'b0110, 32'h0000_C3B2, 32'h00C3_B200};
    vecs[5] = '{4'b0101, 32'hDEAD_2211, 32'h0022_0011};

    model_reset();
    #12;
    chk("reset v_o", 64'(v_o), 64'h0);
    chk("reset busy_o", 64'(busy_o), 64'h0);
    chk("reset data_o", 64'(data_o), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset ready_o", 64'(ready_o), 64'h1);
    @(negedge clk);

    // Single-transaction table, all lanes ready.
    for (int i = 0; i < 6; i++) begin
      v_i = 1'b1; mask_i = vecs[i].mask; data_i = vecs[i].data; ready_i = '1;
      tick();
      v_i = 1'b0;
      #1;
      chk("tbl v_o", 64'(v_o), 64'(vecs[i].mask));
      chk("tbl data_o", 64'(data_o), 64'(vecs[i].exp_d));
      tick();
      #1;
      chk("tbl v_o after", 64'(v_o), 64'h0);
      chk("tbl ready_o after", 64'(ready_o), 64'h1);
      @(negedge clk);
    end

    // Partial stall: lanes 1/3 held for three cycles.
    v_i = 1'b1; mask_i = 4'b1111; data_i = 32'h4433_2211; ready_i = '1;
    tick();
    v_i = 1'b0; ready_i = 4'b0101;
    tick(); tick(); tick();
    #1;
    chk("stall v_o", 64'(v_o), 64'b1010);
    chk("stall lane1", 64'(data_o[15:8]), 64'h22);
    chk("stall lane3", 64'(data_o[31:24]), 64'h44);
    chk("stall busy", 64'(busy_o), 64'h1);
    ready_i = 4'b1111;
    tick();
    #1;
    chk("stall done v_o", 64'(v_o), 64'h0);
    chk("stall done ready", 64'(ready_o), 64'h1);
    @(negedge clk);

    // Zero mask is consumed without effect.
    v_i = 1'b1; mask_i = '0; data_i = 32'hCAFE_F00D;
    tick(); tick();
    v_i = 1'b0;
    #1;
    chk("zero v_o", 64'(v_o), 64'h0);
    chk("zero busy", 64'(busy_o), 64'h0);
    chk("zero ready", 64'(ready_o), 64'h1);
    @(negedge clk);

    // Asynchronous reset while draining.
    v_i = 1'b1; mask_i = 4'b0011; data_i = 32'h0000_6655; ready_i = '0;
    tick();
    v_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst mid v_o", 64'(v_o), 64'h0);
    chk("rst mid busy", 64'(busy_o), 64'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();

    // Back-to-back throughput on lane 0.
    lane0_log.delete();
    ready_i = '1; mask_i = 4'b0001; v_i = 1'b1;
    sent = 0; edges = 0;
    data_i = 32'(sent + 1);
    while (!(sent == 8 && owed() == '0) && edges < 40) begin
      tick();
      edges++;
      if (last_acc) sent++;
      if (sent == 8) v_i = 1'b0;
      data_i = 32'(sent + 1);
    end
    chk("b2b cycles", 64'(edges), Byp ? 64'd9 : 64'd16);
    chk("b2b count", 64'(lane0_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < lane0_log.size(); i++)
      chk("b2b order", 64'(lane0_log[i]), 64'(i + 1));

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      v_i     = ($urandom_range(0, 9) < 7);
      mask_i  = 4'($urandom_range(0, 15));
      data_i  = $urandom;
      ready_i = 4'($urandom) | 4'($urandom);
      tick();
    end
    v_i = 1'b0; ready_i = '1;
    for (int n = 0; n < 10 && owed() != '0; n++) tick();
    chk("final drained", 64'(owed()), 64'h0);
    #1;
    chk("final v_o", 64'(v_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
